// File: rtl/fp32_add_seq_ctrl_if.sv
// Handshake bundle between the MAC scheduler, the FP32 add sequencer and the accumulator file.
// The sequencer takes the slave side; the scheduler/consumer side is the master.
interface fp32_add_seq_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;

   modport master (
      output in_valid, op_a, op_b, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, op_a, op_b, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/fp32_add_seq_ctrl.sv
// Multi-cycle FP32 adder sequencer: unpack/special-case, align, signed-magnitude add,
// iterative normalise and pack, with truncating rounding and denormal flushing.
module fp32_add_seq_ctrl #(
   parameter int          FLUSH_DENORM = 1,
   parameter logic [31:0] QNAN         = 32'h7FC00000
) (
   input logic                clk,
   input logic                rst_n,
   fp32_add_seq_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, PACK, DONE} state_t;
   state_t state, state_next;

   logic        sign_a, sign_b, sign_r;
   logic [7:0]  exp_a, exp_b;
   logic [23:0] man_a, man_b;
   logic [8:0]  exp_r;
   logic [24:0] sum;
   logic        special;
   logic [31:0] special_val;
   logic [31:0] result_r;

   logic        in_sa, in_sb;
   logic [7:0]  in_ea, in_eb;
   logic [22:0] in_fa, in_fb;
   logic [23:0] in_ma, in_mb;
   logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
   logic        in_special;
   logic [31:0] in_special_val;
   logic        accept;
   logic        a_ge_b;
   logic [7:0]  exp_diff;
   logic        norm_done;

   function automatic logic [23:0] unpack_man(input logic [7:0] e, input logic [22:0] f);
      if (e == 8'd0) return (FLUSH_DENORM != 0) ? 24'd0 : {1'b0, f};
      return {1'b1, f};
   endfunction

   assign {in_sa, in_ea, in_fa} = bus.op_a;
   assign {in_sb, in_eb, in_fb} = bus.op_b;
   assign in_ma  = unpack_man(in_ea, in_fa);
   assign in_mb  = unpack_man(in_eb, in_fb);
   assign nan_a  = (in_ea == 8'hFF) && (in_fa != 23'd0);
   assign nan_b  = (in_eb == 8'hFF) && (in_fb != 23'd0);
   assign inf_a  = (in_ea == 8'hFF) && (in_fa == 23'd0);
   assign inf_b  = (in_eb == 8'hFF) && (in_fb == 23'd0);
   assign zero_a = (in_ma == 24'd0);
   assign zero_b = (in_mb == 24'd0);
   assign accept = bus.in_valid && (state == IDLE);

   // Results that need no arithmetic are decided at accept and skip straight to PACK
   always_comb begin
      in_special     = nan_a || nan_b || inf_a || inf_b || (zero_a && zero_b);
      in_special_val = {in_sa & in_sb, 31'd0};
      if (nan_a || nan_b)                      in_special_val = QNAN;
      else if (inf_a && inf_b && (in_sa != in_sb)) in_special_val = QNAN;
      else if (inf_a)                          in_special_val = bus.op_a;
      else if (inf_b)                          in_special_val = bus.op_b;
   end

   assign a_ge_b    = (exp_a >= exp_b);
   assign exp_diff  = a_ge_b ? (exp_a - exp_b) : (exp_b - exp_a);
   assign norm_done = sum[24] || (sum == 25'd0) || sum[23] || (exp_r <= 9'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = in_special ? PACK : ALIGN;
         ALIGN:   state_next = ADD;
         ADD:     state_next = NORM;
         NORM:    if (norm_done) state_next = PACK;
         PACK:    state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         sign_r      <= 1'b0;
         exp_a       <= 8'd0;
         exp_b       <= 8'd0;
         man_a       <= 24'd0;
         man_b       <= 24'd0;
         exp_r       <= 9'd0;
         sum         <= 25'd0;
         special     <= 1'b0;
         special_val <= 32'd0;
         result_r    <= 32'd0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               sign_a      <= in_sa;
               sign_b      <= in_sb;
               exp_a       <= in_ea;
               exp_b       <= in_eb;
               man_a       <= in_ma;
               man_b       <= in_mb;
               special     <= in_special;
               special_val <= in_special_val;
            end
            ALIGN: begin
               if (a_ge_b) begin
                  exp_r <= {1'b0, exp_a};
                  man_b <= (exp_diff >= 8'd24) ? 24'd0 : (man_b >> exp_diff);
               end else begin
                  exp_r <= {1'b0, exp_b};
                  man_a <= (exp_diff >= 8'd24) ? 24'd0 : (man_a >> exp_diff);
               end
            end
            ADD: begin
               if (sign_a == sign_b) begin
                  sum    <= {1'b0, man_a} + {1'b0, man_b};
                  sign_r <= sign_a;
               end else if (man_a >= man_b) begin
                  sum    <= {1'b0, man_a} - {1'b0, man_b};
                  sign_r <= sign_a;
               end else begin
                  sum    <= {1'b0, man_b} - {1'b0, man_a};
                  sign_r <= sign_b;
               end
            end
            // Zero and underflow both collapse to +0 by clearing sign, exponent and sum
            NORM: begin
               if (sum[24]) begin
                  sum   <= sum >> 1;
                  exp_r <= exp_r + 9'd1;
               end else if (sum[23]) begin
                  sum <= sum;
               end else if ((sum == 25'd0) || (exp_r <= 9'd1)) begin
                  sum    <= 25'd0;
                  sign_r <= 1'b0;
                  exp_r  <= 9'd0;
               end else begin
                  sum   <= sum << 1;
                  exp_r <= exp_r - 9'd1;
               end
            end
            PACK: begin
               if (special)               result_r <= special_val;
               else if (exp_r >= 9'd255)  result_r <= {sign_r, 8'hFF, 23'd0};
               else                       result_r <= {sign_r, exp_r[7:0], sum[22:0]};
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);
   assign bus.result    = result_r;
endmodule

// File: tb/tb_fp32_add_seq_ctrl.sv
// Self-checking bench for fp32_add_seq_ctrl: table of directed FP32 sums with expected
// result and latency, plus hand sequences for backpressure and reset during NORM.
module tb_fp32_add_seq_ctrl;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   fp32_add_seq_ctrl_if bus();

   fp32_add_seq_ctrl #(
      .FLUSH_DENORM(1),
      .QNAN        (32'h7FC00000)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      int          exp_lat;
   } vec_t;

   localparam int NVEC = 16;
   vec_t vecs[NVEC];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Handshakes one operand pair in, then waits (bounded) for out_valid; latency counted from the accept edge
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                output int lat, output logic [31:0] res);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) begin
            lat = k + 1;
            break;
         end
      end
      res = bus.result;
   endtask

   initial begin
      int          lat;
      logic [31:0] res;

      vecs[0]  = '{32'h3F800000, 32'h40000000, 32'h40400000, 5};
      vecs[1]  = '{32'h3FC00000, 32'hBFA00000, 32'h3E800000, 7};
      vecs[2]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 5};
      vecs[3]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 2};
      vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 5};
      vecs[5]  = '{32'h00000001, 32'h3F800000, 32'h3F800000, 5};
      vecs[6]  = '{32'h4B800000, 32'h3F800000, 32'h4B800000, 5};
      vecs[7]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2};
      vecs[8]  = '{32'h80000000, 32'h80000000, 32'h80000000, 2};
      vecs[9]  = '{32'h00000000, 32'h80000000, 32'h00000000, 2};
      vecs[10] = '{32'hFF800000, 32'h3F800000, 32'hFF800000, 2};
      vecs[11] = '{32'h40400000, 32'hC0000000, 32'h3F800000, 6};
      vecs[12] = '{32'h3F800000, 32'hC0000000, 32'hBF800000, 6};
      vecs[13] = '{32'h3F800001, 32'hBF800000, 32'h34000000, 28};
      vecs[14] = '{32'h00800001, 32'h80800000, 32'h00000000, 5};
      vecs[15] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 5};

      checks       = 0;
      failures     = 0;
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      bus.op_a     = 32'd0;
      bus.op_b     = 32'd0;
      bus.out_ready = 1'b1;
      #3 rst_n = 1'b0;
      #4;
      checkOutput("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
      checkOutput("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("reset result", bus.result, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, lat, res);
         checkOutput($sformatf("vec%0d result", i), res, vecs[i].exp_res);
         checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d single pulse", i), {31'd0, bus.out_valid}, 32'd0);
      end

      // Backpressure: result held, new operands ignored, exactly one transfer on release
      bus.out_ready = 1'b0;
      applyStimulus(32'h3F800000, 32'h40000000, lat, res);
      checkOutput("bp result", res, 32'h40400000);
      checkOutput("bp latency", lat, 5);
      for (int i = 0; i < 10; i++) begin
         if (i == 2) begin
            bus.in_valid = 1'b1;
            bus.op_a     = 32'h7F800000;
            bus.op_b     = 32'h3F800000;
         end
         if (i == 5) bus.in_valid = 1'b0;
         @(posedge clk);
         #1;
         checkOutput($sformatf("bp hold result %0d", i), bus.result, 32'h40400000);
         checkOutput($sformatf("bp hold valid %0d", i), {31'd0, bus.out_valid}, 32'd1);
         checkOutput($sformatf("bp hold in_ready %0d", i), {31'd0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp release valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("bp release in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput("bp no second result", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("bp idle busy", {31'd0, bus.busy}, 32'd0);

      // Reset while the long-normalise vector is sitting in NORM
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.op_a     = 32'h3F800001;
      bus.op_b     = 32'hBF800000;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("norm busy", {31'd0, bus.busy}, 32'd1);
      checkOutput("norm no valid", {31'd0, bus.out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst in_ready", {31'd0, bus.in_ready}, 32'd1);
      checkOutput("midrst out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("midrst busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("midrst result", bus.result, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("postrst idle", {31'd0, bus.busy}, 32'd0);
      applyStimulus(32'h3F800000, 32'h40000000, lat, res);
      checkOutput("postrst result", res, 32'h40400000);
      checkOutput("postrst latency", lat, 5);
      @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule

// File: doc/fp32_add_seq_ctrl.md
Name: fp32_add_seq_ctrl

Overview:
- Multi-cycle sequencer for the signed-magnitude 24-bit mantissa adder used by the matrix multiplier's accumulate path.
- Accepts two IEEE-754 single-precision operands over a valid/ready handshake.
- Sequences the operation through unpack/special-case, exponent align, mantissa add, iterative normalise and pack.
- Returns one FP32 sum per transaction. Sits between the MAC scheduler and the accumulator register file.

Parameters:
- FLUSH_DENORM, 1, when 1 denormal inputs are treated as signed zero and underflowing results flush to +0. Only value 1 is supported.
- QNAN, 32'h7FC00000, canonical NaN pattern emitted for any NaN result.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- op_a  in  32  FP32 operand A
- op_b  in  32  FP32 operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  FP32 sum
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; result=0; busy=0; all internal registers cleared.
- Reset mid-operation aborts the transaction with no output.
- States: IDLE, ALIGN, ADD, NORM, PACK, DONE.
- IDLE: in_ready=1. Accept occurs on in_valid&in_ready; operands are latched and unpacked.
  - Denormal or zero exponent: mantissa=0.
  - Otherwise mantissa={1,frac}.
- Special cases at accept go directly to PACK with a fixed result:
  - NaN input: QNAN.
  - +Inf + -Inf: QNAN.
  - Any other Inf: that Inf.
  - Both zero: sign = sign_a&sign_b, magnitude 0.
- Otherwise the next state is ALIGN.
- ALIGN (1 cycle):
  - exp_r = max(exp_a, exp_b).
  - The smaller-exponent mantissa is shifted right by the difference, with shifted-out bits truncated.
  - A difference >=24 zeroes that mantissa.
- ADD (1 cycle): signed-magnitude add of the two 24-bit mantissas into a 25-bit sum.
  - Equal signs: sum = a+b, sign = common sign.
  - Unequal signs: larger magnitude minus smaller, sign of the larger; ties go to a.
- NORM (1..24 cycles):
  - sum[24]=1: shift right 1, exp_r+1, go PACK.
  - sum=0: result +0, go PACK.
  - sum[23]=1: go PACK.
  - Else: shift left 1, exp_r-1, stay NORM.
  - If exp_r reaches 0 while still unnormalised: flush to +0, go PACK.
- PACK (1 cycle):
  - exp_r>=255 gives {sign,8'hFF,23'h0}.
  - Else {sign,exp_r[7:0],sum[22:0]}.
  - Rounding is truncation (round toward zero).
- DONE:
  - out_valid=1 and result is held stable until out_ready=1.
  - The transfer completes on that edge; the next state is IDLE and out_valid drops the following cycle.
- in_ready=1 only in IDLE; no new operand is accepted while a result is pending.
- Latency, measured from the accept edge T: special cases give out_valid at T+2; normal cases with no left shift give out_valid at T+5; each left shift adds 1 cycle. The worst case is T+28.
- Throughput: at most one transaction in flight; the minimum issue interval is latency+1 cycles.
- out_valid held with out_ready=0: result, out_valid and in_ready=0 are all unchanged indefinitely.
- in_valid asserted while not in IDLE: ignored; the operands are not latched.

Test Plan:
- 0x3F800000 + 0x40000000 (1.0+2.0), out_ready=1 -> result 0x40400000, out_valid at T+5, one pulse.
- 0x3FC00000 + 0xBFA00000 (1.5-1.25) -> 0x3E800000, with 2 extra NORM cycles (out_valid at T+7).
- 0x3F800000 + 0xBF800000 -> 0x00000000; 0x7F800000 + 0xFF800000 -> 0x7FC00000 at T+2; 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> result stable, in_ready=0, a second in_valid is ignored; releasing out_ready completes exactly one transfer.
- Reset asserted during NORM -> all outputs return to reset values immediately; after release, a new 1.0+2.0 gives 0x40400000.
- Denormal 0x00000001 + 0x3F800000 -> 0x3F800000; exponent diff >=24, e.g. 0x4B800000 + 0x3F800000 -> 0x4B800000.
